lab_rom_arbiter: RTL and testbench
==================================

# lab_rom_arbiter

Two-port read arbiter and sequencer for the labyrinth map ROM (12-bit RGB444 words, 8-bit address, 220 entries, one-cycle registered read). It shares the single ROM read port between the VGA pixel fetcher (port 0, priority) and the game-logic collision checker (port 1). It issues at most one ROM read per cycle and tracks the ROM latency with an in-flight tag pipeline. Each port gets its data back with a per-port valid and an out-of-range error flag.

## Interface
- DATA_WIDTH, 12: ROM word width.
- ADDR_WIDTH, 8: ROM address width.
- ROM_SIZE, 220: number of valid ROM entries. Addresses >= ROM_SIZE are out of range.
- MAX_WAIT, 4: consecutive denied cycles for port 1 before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 read request.
- addr0  in  ADDR_WIDTH  port 0 address; held while req0 is high and ack0 is low.
- ack0  out  1  port 0 request accepted this cycle (combinational).
- rvalid0  out  1  port 0 read data valid (one-cycle pulse per accepted request).
- rdata0  out  DATA_WIDTH  port 0 read data.
- rerr0  out  1  port 0 address was out of range; qualified by rvalid0.
- req1, addr1, ack1, rvalid1, rdata1, rerr1: same meanings for port 1.
- rom_addr  out  ADDR_WIDTH  to ROM addr (combinational).
- rom_data  in  DATA_WIDTH  from ROM data_o, valid one cycle after rom_addr.

## Operation
- **Grant rule, evaluated each cycle:**
  - Port 1 wins if req1 is high and the starvation counter is at MAX_WAIT.
  - Otherwise port 0 wins if req0 is high.
  - Otherwise port 1 wins if req1 is high.
  - At most one of ack0/ack1 is high. With no request, neither is high.
- **Handshake:**
  - Requester holds req and addr stable until it sees ack.
  - The request is consumed in the ack cycle.
  - If req stays high after ack, it is a new request.
  - Back-to-back grants are allowed every cycle.
- **Starvation counter (4 bit):**
  - Increments in cycles where req1=1 and ack1=0, saturating at MAX_WAIT.
  - Clears on ack1 or req1=0.
  - Reset value 0.
- **ROM address:**
  - rom_addr = granted address if it is in range, else 0.
  - rom_addr = 0 when idle.
- **Tag pipeline, two stages.** Stage A captures {valid, port, oor} at grant.
- **Return stage:**
  - Stage A result is registered together with rom_data into the returning port's rdata/rerr/rvalid.
  - For an out-of-range request, rdata is forced to 0 and rerr=1.
  - The non-returning port's rvalid is 0.
  - rdata and rerr hold their last value when rvalid=0.
- **Reset:**
  - All outputs (registered and combinational) read 0 during reset.
  - Tags, counter and return registers clear.
  - In-flight reads are discarded: no rvalid is produced for any request acked before reset.
  - ack0/ack1 are forced to 0 while reset=1.

## Timing
- Request acked in cycle t: rom_addr is driven in cycle t, the ROM samples at the end of t, and rom_data is valid in t+1.
- rvalidN is high in cycle t+2. Fixed latency 2; no backpressure on the return path.
- Throughput: one read per cycle total across both ports.
- Out-of-range requests keep the same latency as in-range ones.
- Simultaneous req0 and req1 with counter < MAX_WAIT: ack0 is high. The counter increments, so a continuously requesting port 1 is acked within MAX_WAIT+1 cycles.
- Reset asserted in cycle r: no rvalid in cycles r+1 and r+2. The first possible ack is in the first cycle with reset=0.

## Test plan
- **Single read, port 1.** After reset, req1=1, addr1=8'h05 for one cycle → ack1=1 same cycle; rom_addr=8'h05; rvalid1=1 two cycles later with rdata1=ROM[5], rerr1=0; rvalid0 stays 0.
- **Contention and starvation.** req0 held high for 20 cycles with incrementing addresses, req1=1 with addr1=8'h10 held (MAX_WAIT=4) → ack0 for 4 cycles, ack1 in the 5th cycle; rvalid1 data=ROM[16] two cycles later; port 0 resumes the following cycle; no lost or duplicated port 0 responses (count 19 rvalid0 pulses for 19 acks).
- **Out of range.** req0 with addr0=8'd220, then 8'd255 → ack0; rom_addr=0; rvalid0 two cycles later each with rdata0=0, rerr0=1.
- **Back-to-back alternation.** req0/req1 alternating every cycle with addresses 0..7 → one ack per cycle; responses return in grant order at latency 2, each on its own port with the matching ROM word.
- **Reset mid-flight.** Ack port 0 in cycle t, assert reset in t+1 for one cycle → no rvalid0 in t+2; all outputs 0 during reset; the starvation counter restarts from 0 afterwards (verified by the MAX_WAIT timing above).
- **Idle.** No requests for 10 cycles → ack/rvalid all 0 and rom_addr=0; rdata holds its last value.

Source files
------------

// File: rtl/lab_rom_arbiter.sv
// Two-port read arbiter for the labyrinth map ROM: port 0 (VGA) has priority,
// port 1 (collision checker) is protected from starvation; fixed 2-cycle read latency.
module lab_rom_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int ROM_SIZE   = 220,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  ack0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rerr0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  ack1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rerr1,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    localparam logic [3:0]          WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [ADDR_WIDTH:0] ROM_LIMIT  = (ADDR_WIDTH + 1)'(ROM_SIZE);

    logic [3:0]            wait_cnt;
    logic                  force1;
    logic                  grant0;
    logic                  grant1;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  grant_oor;

    logic                  a_valid;
    logic                  a_port;
    logic                  a_oor;

    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic                  rerr0_q;
    logic                  rerr1_q;

    // Grant: a starved port 1 overrides port 0's priority; nothing is granted in reset.
    always_comb begin
        force1     = req1 && (wait_cnt == WAIT_LIMIT);
        grant1     = !reset && req1 && (force1 || !req0);
        grant0     = !reset && req0 && !force1;
        grant_any  = grant0 || grant1;
        grant_addr = grant1 ? addr1 : addr0;
        grant_oor  = ({1'b0, grant_addr} >= ROM_LIMIT);
        rom_addr   = (grant_any && !grant_oor) ? grant_addr : '0;
    end

    assign ack0 = grant0;
    assign ack1 = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!req1 || grant1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Stage A follows the read the ROM is performing this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_port  <= 1'b0;
            a_oor   <= 1'b0;
        end else begin
            a_valid <= grant_any;
            a_port  <= grant1;
            a_oor   <= grant_oor;
        end
    end

    // Return stage: only the owning port's registers load, so the other port holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rerr0_q   <= 1'b0;
            rerr1_q   <= 1'b0;
        end else begin
            rvalid0_q <= a_valid && !a_port;
            rvalid1_q <= a_valid && a_port;
            if (a_valid && !a_port) begin
                rdata0_q <= a_oor ? '0 : rom_data;
                rerr0_q  <= a_oor;
            end
            if (a_valid && a_port) begin
                rdata1_q <= a_oor ? '0 : rom_data;
                rerr1_q  <= a_oor;
            end
        end
    end

    // Registered outputs are masked so everything reads zero while reset is held.
    always_comb begin
        rvalid0 = rvalid0_q && !reset;
        rvalid1 = rvalid1_q && !reset;
        rdata0  = reset ? '0 : rdata0_q;
        rdata1  = reset ? '0 : rdata1_q;
        rerr0   = rerr0_q && !reset;
        rerr1   = rerr1_q && !reset;
    end

endmodule

// File: tb/tb_lab_rom_arbiter.sv
// Self-checking bench for lab_rom_arbiter: vector table for grants/rom_addr plus a
// scoreboard that predicts every read return from its own ROM model.
module tb_lab_rom_arbiter;

    logic        clk;
    logic        reset;
    logic        req0;
    logic [7:0]  addr0;
    logic        ack0;
    logic        rvalid0;
    logic [11:0] rdata0;
    logic        rerr0;
    logic        req1;
    logic [7:0]  addr1;
    logic        ack1;
    logic        rvalid1;
    logic [11:0] rdata1;
    logic        rerr1;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;

    typedef struct {
        logic       rst;
        logic       r0;
        logic [7:0] a0;
        logic       r1;
        logic [7:0] a1;
        logic       e_ack0;
        logic       e_ack1;
        logic [7:0] e_rom;
    } vec_t;

    typedef struct {
        logic        port;
        logic [11:0] data;
        logic        err;
        int          due;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    exp_t        head;
    int          tests = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rv0_count = 0;
    logic [11:0] last_data0 = '0;
    logic [11:0] last_data1 = '0;

    lab_rom_arbiter #(
        .DATA_WIDTH(12),
        .ADDR_WIDTH(8),
        .ROM_SIZE(220),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .addr0(addr0),
        .ack0(ack0),
        .rvalid0(rvalid0),
        .rdata0(rdata0),
        .rerr0(rerr0),
        .req1(req1),
        .addr1(addr1),
        .ack1(ack1),
        .rvalid1(rvalid1),
        .rdata1(rdata1),
        .rerr1(rerr1),
        .rom_addr(rom_addr),
        .rom_data(rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] rom_word(input logic [7:0] a);
        return {a ^ 8'h5A, a[3:0]};
    endfunction

    // ROM stand-in: one-cycle registered read.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic r0, input logic [7:0] a0,
                                 input logic r1, input logic [7:0] a1);
        @(posedge clk);
        #1;
        reset = rst;
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        @(negedge clk);
    endtask

    task automatic addVec(input logic rst, input logic r0, input logic [7:0] a0, input logic r1,
                          input logic [7:0] a1, input logic e0, input logic e1, input logic [7:0] er);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.e_ack0 = e0; v.e_ack1 = e1; v.e_rom = er;
        vecs.push_back(v);
    endtask

    function automatic exp_t predict(input logic port, input logic [7:0] a, input int due);
        exp_t e;
        e.port = port;
        e.err  = (a >= 8'd220);
        e.data = e.err ? 12'h000 : rom_word(a);
        e.due  = due;
        return e;
    endfunction

    // Scoreboard: acks push predictions due two cycles later; returns are checked in order.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            checkOutput("rvalid0_in_reset", rvalid0, 0);
            checkOutput("rvalid1_in_reset", rvalid1, 0);
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                head = sb.pop_front();
                checkOutput(head.port ? "rvalid1_due" : "rvalid0_due", head.port ? rvalid1 : rvalid0, 1);
                checkOutput(head.port ? "rvalid0_idle" : "rvalid1_idle", head.port ? rvalid0 : rvalid1, 0);
                checkOutput(head.port ? "rdata1" : "rdata0", head.port ? rdata1 : rdata0, head.data);
                checkOutput(head.port ? "rerr1" : "rerr0", head.port ? rerr1 : rerr0, head.err);
                if (head.port) last_data1 = head.data;
                else last_data0 = head.data;
            end else begin
                checkOutput("rvalid0_unexpected", rvalid0, 0);
                checkOutput("rvalid1_unexpected", rvalid1, 0);
            end
            if (rvalid0) rv0_count++;
            if (ack0) sb.push_back(predict(1'b0, addr0, cyc + 2));
            if (ack1) sb.push_back(predict(1'b1, addr1, cyc + 2));
        end
    end

    initial begin
        int rv0_start;
        logic got1;

        reset = 1'b1; req0 = 1'b0; addr0 = '0; req1 = 1'b0; addr1 = '0;

        // Table: single port-1 read, out-of-range, alternation, contention, idle.
        addVec(0, 0, 8'h00, 1, 8'h05, 0, 1, 8'h05);
        addVec(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        addVec(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        addVec(0, 1, 8'd220, 0, 8'h00, 1, 0, 8'h00);
        addVec(0, 1, 8'd255, 0, 8'h00, 1, 0, 8'h00);
        addVec(0, 1, 8'h10, 0, 8'h00, 1, 0, 8'h10);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) addVec(0, 1, 8'(i), 0, 8'h00, 1, 0, 8'(i));
            else            addVec(0, 0, 8'h00, 1, 8'(i), 0, 1, 8'(i));
        end
        addVec(0, 1, 8'h03, 1, 8'h07, 1, 0, 8'h03);
        addVec(0, 0, 8'h00, 1, 8'h07, 0, 1, 8'h07);
        for (int i = 0; i < 10; i++) addVec(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 8'h05, 1, 8'h06);
            checkOutput("reset_ack0", ack0, 0);
            checkOutput("reset_ack1", ack1, 0);
            checkOutput("reset_rom_addr", rom_addr, 0);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1);
            checkOutput($sformatf("vec%0d_ack0", i), ack0, vecs[i].e_ack0);
            checkOutput($sformatf("vec%0d_ack1", i), ack1, vecs[i].e_ack1);
            checkOutput($sformatf("vec%0d_rom_addr", i), rom_addr, vecs[i].e_rom);
        end
        checkOutput("idle_hold_rdata0", rdata0, last_data0);
        checkOutput("idle_hold_rdata1", rdata1, last_data1);
        checkOutput("idle_hold_rdata0_value", rdata0, rom_word(8'h03));

        // Reset one cycle after an ack: the in-flight read must vanish.
        applyStimulus(0, 1, 8'h09, 0, 8'h00);
        checkOutput("midflight_ack0", ack0, 1);
        applyStimulus(1, 1, 8'h09, 1, 8'h20);
        checkOutput("midreset_ack0", ack0, 0);
        checkOutput("midreset_ack1", ack1, 0);
        checkOutput("midreset_rom_addr", rom_addr, 0);
        checkOutput("midreset_rdata0", rdata0, 0);
        checkOutput("midreset_rdata1", rdata1, 0);
        checkOutput("midreset_rerr0", rerr0, 0);
        checkOutput("midreset_rerr1", rerr1, 0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00);
        checkOutput("after_reset_rvalid0", rvalid0, 0);

        // Starvation: port 0 requests continuously, port 1 must win on the 5th cycle.
        rv0_start = rv0_count;
        got1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 1, 8'(k + 32), !got1, 8'h10);
            checkOutput($sformatf("starve%0d_ack0", k), ack0, (k != 4));
            checkOutput($sformatf("starve%0d_ack1", k), ack1, (k == 4));
            if (ack1) got1 = 1'b1;
        end
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 8'h00, 0, 8'h00);
        checkOutput("starve_rvalid0_count", rv0_count - rv0_start, 19);
        checkOutput("scoreboard_drained", sb.size(), 0);
        checkOutput("starve_rdata1", rdata1, rom_word(8'h10));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
